// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: request/ready handshake with WAIT_CYCLES wait states,
// registered load data and an error flag for misaligned or out-of-range accesses.
module dmem_responder #(
    parameter int unsigned AW_WORDS    = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        Wmem,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        Ready,
    output logic        Err
);

    if (WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0]  WAIT4 = 4'(WAIT_CYCLES);
    localparam int unsigned DEPTH = 1 << AW_WORDS;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic                wmem_q, wmem_d;
    logic [31:0]         dout_q, dout_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                wr_pend_q, wr_pend_d;
    logic [AW_WORDS-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic                commit;
    logic [31:0]         c_addr;
    logic [31:0]         c_din;
    logic                c_wmem;
    logic                c_err;
    logic [AW_WORDS-1:0] c_idx;

    logic [31:0]         mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wmem_d    = wmem_q;
        dout_d    = dout_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        wr_pend_d = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        commit    = 1'b0;
        c_addr    = addr_q;
        c_din     = din_q;
        c_wmem    = wmem_q;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    addr_d = Addr;
                    din_d  = Din;
                    wmem_d = Wmem;
                    cnt_d  = WAIT4;
                    if (WAIT4 == 4'd0) begin
                        // zero wait states: the acceptance edge is also the commit edge
                        state_d = DONE;
                        commit  = 1'b1;
                        c_addr  = Addr;
                        c_din   = Din;
                        c_wmem  = Wmem;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        c_err = (c_addr[1:0] != 2'b00) || ((c_addr >> (AW_WORDS + 2)) != 32'd0);
        c_idx = c_addr[AW_WORDS+1:2];

        if (commit) begin
            ready_d = 1'b1;
            err_d   = c_err;
            if (c_wmem) begin
                wr_pend_d = !c_err;
                wr_idx_d  = c_idx;
                wr_data_d = c_din;
            end else begin
                dout_d = c_err ? '0 : mem[c_idx];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wmem_q    <= 1'b0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wmem_q    <= wmem_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Store lands one edge after commit (during DONE); no new access can read before then,
    // and the reset-cleared pending flag keeps Rst out of the unreset array's logic.
    always_ff @(posedge Clk) begin
        if (wr_pend_q) begin
            mem[wr_idx_q] <= wr_data_q;
        end
    end

    assign Dout  = dout_q;
    assign Ready = ready_q;
    assign Err   = err_q;

endmodule
